// File: rtl/flow_pkg.sv
// flow_pkg: shared state encoding, defaults and product scheduling for the sequential flow solver
package flow_pkg;
  typedef enum logic [2:0] {IDLE, MUL, CHECK, DIV_U, DIV_V, DONE} solver_state_e;
  localparam int DEF_DET_THRESHOLD = 1000;
  localparam int DEF_FLOW_CLAMP    = 1024;
  localparam int DEF_FLOW_WIDTH    = 16;
  localparam int DEF_FRAC_BITS     = 7;
  localparam logic [2:0] S_XX = 3'd0, S_YY = 3'd1, S_XY = 3'd2, S_XT = 3'd3, S_YT = 3'd4;
  localparam logic [2:0] LAST_PROD = 3'd5;
  // Even products are minuends, odd ones subtrahends: det, num_u, num_v in pairs
  function automatic logic [2:0] op_a(input logic [2:0] k);
    return (k == 3'd0 || k == 3'd4) ? S_XX : (k == 3'd2) ? S_YY : S_XY;
  endfunction
  function automatic logic [2:0] op_b(input logic [2:0] k);
    return (k == 3'd0) ? S_YY : (k == 3'd1) ? S_XY : (k == 3'd2 || k == 3'd5) ? S_XT : S_YT;
  endfunction
endpackage

// File: rtl/flow_solver_if.sv
// flow_solver_if: window-in / flow-out handshake bundle plus status
interface flow_solver_if #(
  parameter int ACCUM_WIDTH = 32,
  parameter int FLOW_WIDTH  = 16,
  parameter int CNT_WIDTH   = 16
);
  logic                          in_valid, in_ready;
  logic signed [ACCUM_WIDTH-1:0] sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt;
  logic [9:0]                    pixel_x_in, pixel_x_out;
  logic [8:0]                    pixel_y_in, pixel_y_out;
  logic                          out_valid, out_ready;
  logic signed [FLOW_WIDTH-1:0]  flow_u, flow_v;
  logic                          busy;
  logic [CNT_WIDTH-1:0]          reject_count;
  modport master (
    output in_valid, sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt, pixel_x_in, pixel_y_in, out_ready,
    input  in_ready, out_valid, flow_u, flow_v, pixel_x_out, pixel_y_out, busy, reject_count
  );
  modport slave (
    input  in_valid, sum_IxIx, sum_IyIy, sum_IxIy, sum_IxIt, sum_IyIt, pixel_x_in, pixel_y_in, out_ready,
    output in_ready, out_valid, flow_u, flow_v, pixel_x_out, pixel_y_out, busy, reject_count
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: bit-serial restoring unsigned divider, one quotient bit per cycle
module seq_divider #(
  parameter int DVD_W = 39,
  parameter int DVS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quotient
);
  localparam int CW = $clog2(DVD_W + 1);
  logic [DVS_W-1:0] r_rem, r_dvs, w_rem;
  logic [DVD_W-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic [DVS_W:0]   w_sh;
  logic [DVS_W+1:0] w_diff;
  logic             w_ge;
  assign w_sh   = {r_rem, r_quo[DVD_W-1]};
  assign w_diff = {1'b0, w_sh} - {2'b0, r_dvs};
  assign w_ge   = !w_diff[DVS_W+1];
  assign w_rem  = w_ge ? w_diff[DVS_W-1:0] : w_sh[DVS_W-1:0];
  // Done and the final quotient are presented during the last iteration so the caller can chain
  assign o_quotient = {r_quo[DVD_W-2:0], w_ge};
  assign o_done     = r_cnt == CW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_dvs <= '0;
      r_quo <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_dvs <= i_divisor;
      r_quo <= i_dividend;
      r_cnt <= CW'(DVD_W);
    end else if (r_cnt != '0) begin
      r_rem <= w_rem;
      r_quo <= o_quotient;
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/flow_solver_seq.sv
// flow_solver_seq: multi-cycle 2x2 Lucas-Kanade solve sharing one multiplier and one serial divider
module flow_solver_seq
  import flow_pkg::*;
#(
  parameter int ACCUM_WIDTH   = 32,
  parameter int FLOW_WIDTH    = DEF_FLOW_WIDTH,
  parameter int FRAC_BITS     = DEF_FRAC_BITS,
  parameter int DET_THRESHOLD = DEF_DET_THRESHOLD,
  parameter int FLOW_CLAMP    = DEF_FLOW_CLAMP,
  parameter int CNT_WIDTH     = 16
) (
  input logic          clk,
  input logic          rst,
  flow_solver_if.slave s
);
  localparam int DIV_BITS = ACCUM_WIDTH + FRAC_BITS;
  localparam logic signed [ACCUM_WIDTH-1:0] TH = ACCUM_WIDTH'(DET_THRESHOLD);
  solver_state_e                 r_state;
  logic [2:0]                    r_mul_idx;
  logic signed [ACCUM_WIDTH-1:0] r_sum [5];
  logic signed [ACCUM_WIDTH-1:0] r_acc [3];
  logic [9:0]                    r_px, r_px_out;
  logic [8:0]                    r_py, r_py_out;
  logic                          r_in_ready, r_out_valid, r_busy;
  logic signed [FLOW_WIDTH-1:0]  r_flow_u, r_flow_v;
  logic [CNT_WIDTH-1:0]          r_rej;
  logic signed [ACCUM_WIDTH-1:0] w_prod, w_det, w_num_start, w_num_div;
  logic [ACCUM_WIDTH-1:0]        w_det_mag, w_num_mag;
  logic                          w_solvable, w_div_start, w_div_done, w_neg;
  logic [DIV_BITS-1:0]           w_quo;
  logic [FLOW_WIDTH-1:0]         w_mag;
  logic signed [FLOW_WIDTH-1:0]  w_flow;
  assign w_prod      = r_sum[op_a(r_mul_idx)] * r_sum[op_b(r_mul_idx)];
  assign w_det       = r_acc[0];
  assign w_det_mag   = w_det[ACCUM_WIDTH-1] ? -w_det : w_det;
  assign w_solvable  = (w_det > TH) || (w_det < -TH);
  assign w_num_start = (r_state == CHECK) ? r_acc[1] : r_acc[2];
  assign w_num_mag   = w_num_start[ACCUM_WIDTH-1] ? -w_num_start : w_num_start;
  assign w_div_start = (r_state == CHECK && w_solvable) || (r_state == DIV_U && w_div_done);
  assign w_num_div   = (r_state == DIV_V) ? r_acc[2] : r_acc[1];
  assign w_neg       = w_num_div[ACCUM_WIDTH-1] ^ w_det[ACCUM_WIDTH-1];
  assign w_mag       = (w_quo > DIV_BITS'(FLOW_CLAMP)) ? FLOW_WIDTH'(FLOW_CLAMP) : w_quo[FLOW_WIDTH-1:0];
  assign w_flow      = w_neg ? -w_mag : w_mag;
  seq_divider #(.DVD_W(DIV_BITS), .DVS_W(ACCUM_WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend ({w_num_mag, {FRAC_BITS{1'b0}}}),
    .i_divisor  (w_det_mag),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mul_idx   <= '0;
      r_sum       <= '{default: '0};
      r_acc       <= '{default: '0};
      r_px        <= '0;
      r_py        <= '0;
      r_px_out    <= '0;
      r_py_out    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_flow_u    <= '0;
      r_flow_v    <= '0;
      r_rej       <= '0;
    end else begin
      case (r_state)
        IDLE: if (s.in_valid && r_in_ready) begin
          r_sum      <= '{s.sum_IxIx, s.sum_IyIy, s.sum_IxIy, s.sum_IxIt, s.sum_IyIt};
          r_px       <= s.pixel_x_in;
          r_py       <= s.pixel_y_in;
          r_mul_idx  <= '0;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
          r_state    <= MUL;
        end else r_in_ready <= 1'b1;
        MUL: begin
          r_acc[r_mul_idx[2:1]] <= r_mul_idx[0] ? r_acc[r_mul_idx[2:1]] - w_prod : w_prod;
          r_mul_idx <= r_mul_idx + 3'd1;
          if (r_mul_idx == LAST_PROD) r_state <= CHECK;
        end
        CHECK: if (w_solvable) r_state <= DIV_U;
        else begin
          r_flow_u    <= '0;
          r_flow_v    <= '0;
          r_rej       <= &r_rej ? r_rej : r_rej + CNT_WIDTH'(1);
          r_px_out    <= r_px;
          r_py_out    <= r_py;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DIV_U: if (w_div_done) begin
          r_flow_u <= w_flow;
          r_state  <= DIV_V;
        end
        DIV_V: if (w_div_done) begin
          r_flow_v    <= w_flow;
          r_px_out    <= r_px;
          r_py_out    <= r_py;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (s.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign s.in_ready     = r_in_ready;
  assign s.out_valid    = r_out_valid;
  assign s.flow_u       = r_flow_u;
  assign s.flow_v       = r_flow_v;
  assign s.pixel_x_out  = r_px_out;
  assign s.pixel_y_out  = r_py_out;
  assign s.busy         = r_busy;
  assign s.reject_count = r_rej;
endmodule

// File: tb/tb_flow_solver_seq.sv
// tb_flow_solver_seq: randomized and directed windows checked against a plain-arithmetic solve model
module tb_flow_solver_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  flow_solver_if bus ();
  flow_solver_seq dut (.clk(clk), .rst(rst), .s(bus));

  typedef struct { int u; int v; int px; int py; bit rej; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_pass = 0;
  int rej_seen = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic int quot(input int n, input int d);
    longint q = (longint'(n) * 128) / longint'(d);
    if (q > 1024) q = 1024;
    if (q < -1024) q = -1024;
    return int'(q);
  endfunction

  function automatic exp_t model(input int xx, yy, xy, xt, yt, px, py);
    exp_t e;
    int det = xx * yy - xy * xy;
    e.rej = (det >= -1000) && (det <= 1000);
    e.u   = e.rej ? 0 : quot(yy * xt - xy * yt, det);
    e.v   = e.rej ? 0 : quot(xx * yt - xy * xt, det);
    e.px  = px;
    e.py  = py;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        mon_e = exp_q[0];
        chk("mon_flow_u", bus.flow_u, mon_e.u);
        chk("mon_flow_v", bus.flow_v, mon_e.v);
        chk("mon_px", bus.pixel_x_out, mon_e.px);
        chk("mon_py", bus.pixel_y_out, mon_e.py);
        chk("mon_reject_count", bus.reject_count, rej_seen + int'(mon_e.rej));
        if (bus.out_ready) begin
          rej_seen += int'(mon_e.rej);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic accept(input int xx, yy, xy, xt, yt, px, py, output exp_t e);
    int g = 0;
    while (!bus.in_ready && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.sum_IxIx = xx; bus.sum_IyIy = yy; bus.sum_IxIy = xy;
    bus.sum_IxIt = xt; bus.sum_IyIt = yt;
    bus.pixel_x_in = 10'(px); bus.pixel_y_in = 9'(py);
    bus.in_valid = 1'b1;
    e = model(xx, yy, xy, xt, yt, px, py);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.sum_IxIx = $urandom; bus.sum_IyIy = $urandom; bus.sum_IxIy = $urandom;
    bus.sum_IxIt = $urandom; bus.sum_IyIt = $urandom;
    bus.pixel_x_in = 10'($urandom); bus.pixel_y_in = 9'($urandom);
    chk("busy_after_accept", bus.busy, 1);
  endtask

  task automatic wait_out(input int exp_lat);
    int lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic run(input int xx, yy, xy, xt, yt, px, py, hold);
    exp_t e;
    accept(xx, yy, xy, xt, yt, px, py, e);
    wait_out(e.rej ? 7 : 85);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_clear", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
    chk("busy_clear", bus.busy, 0);
  endtask

  task automatic directed(input string n, input int xx, yy, xy, xt, yt, px, py, u, v, rej);
    run(xx, yy, xy, xt, yt, px, py, int'($urandom_range(0, 2)));
    chk({n, "_u"}, bus.flow_u, u);
    chk({n, "_v"}, bus.flow_v, v);
    chk({n, "_px"}, bus.pixel_x_out, px);
    chk({n, "_py"}, bus.pixel_y_out, py);
    chk({n, "_rej"}, bus.reject_count, rej);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.sum_IxIx = 0; bus.sum_IyIy = 0; bus.sum_IxIy = 0; bus.sum_IxIt = 0; bus.sum_IyIt = 0;
    bus.pixel_x_in = '0; bus.pixel_y_in = '0;
    m = model(100, 100, 0, 200, -100, 0, 0);
    chk("model_pin_u", m.u, 256);
    chk("model_pin_v", m.v, -128);
    m = model(30, 30, 0, 5, 5, 0, 0);
    chk("model_pin_rej", m.rej, 1);
    m = model(40, 40, 0, 10000, -10000, 0, 0);
    chk("model_pin_clamp", m.u, 1024);
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_reject", bus.reject_count, 0);
    chk("rst_flow_u", bus.flow_u, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_rise", bus.in_ready, 1);

    directed("case1", 100, 100, 0, 200, -100, 17, 33, 256, -128, 0);
    directed("case2", 30, 30, 0, 5, 5, 600, 400, 0, 0, 1);
    directed("case3", 40, 40, 0, 10000, -10000, 1023, 511, 1024, -1024, 1);
    directed("case4", 1000, 1000, 0, -1001, 1001, 3, 4, -128, 128, 1);
    directed("case5", -1000, 1000, 0, -1001, 1001, 5, 6, 128, 128, 1);
    directed("case6", -1000, -1000, 0, -1001, 1001, 7, 8, 128, -128, 1);

    // Backpressure: result held while the consumer stalls, input pulses ignored
    begin
      exp_t e;
      bus.out_ready = 1'b0;
      accept(100, 100, 0, 200, -100, 55, 66, e);
      wait_out(85);
      repeat (10) begin
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_flow_u", bus.flow_u, 256);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", bus.out_valid, 0);
      chk("bp_release_in_ready", bus.in_ready, 1);
    end
    directed("after_bp", 40, 40, 0, 10000, -10000, 9, 10, 1024, -1024, 1);

    // Reset in the middle of the u division abandons the window
    begin
      exp_t e;
      accept(30, 30, 0, 5, 5, 100, 200, e);
      wait_out(7);
      @(posedge clk); #1;
      accept(100, 100, 0, 200, -100, 77, 88, e);
      repeat (30) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      rej_seen = 0;
      #2;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_reject", bus.reject_count, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
    end
    directed("post_rst", 100, 100, 0, 200, -100, 123, 45, 256, -128, 0);

    for (int i = 0; i < 16; i++) begin
      int md, xx, yy, xy, xt, yt;
      md = int'($urandom_range(0, 3));
      case (md)
        0: begin
          xx = int'($urandom_range(0, 600)) - 300; yy = int'($urandom_range(0, 600)) - 300;
          xy = int'($urandom_range(0, 200)) - 100;
          xt = int'($urandom_range(0, 6000)) - 3000; yt = int'($urandom_range(0, 6000)) - 3000;
        end
        1: begin
          xx = $urandom; yy = $urandom; xy = $urandom; xt = $urandom; yt = $urandom;
        end
        2: begin
          xx = int'($urandom_range(0, 31)); yy = int'($urandom_range(0, 31));
          xy = int'($urandom_range(0, 3));
          xt = int'($urandom_range(0, 100)) - 50; yt = int'($urandom_range(0, 100)) - 50;
        end
        default: begin
          xx = int'($urandom_range(1000, 5000)); yy = int'($urandom_range(1000, 5000));
          xy = int'($urandom_range(0, 1000)) - 500;
          xt = int'($urandom_range(0, 400000)) - 200000; yt = int'($urandom_range(0, 400000)) - 200000;
        end
      endcase
      run(xx, yy, xy, xt, yt, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
          int'($urandom_range(0, 3)));
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
